// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage pipeline front end.
//   INSTR_W   : instruction word width
//   PC_STEP   : byte distance between sequential instruction words
//   NOP_INSTR : instruction word shown when no real instruction is present
//   FetchEntry: one queued fetch result, the PC travelling with its word
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } FetchEntry;

    localparam int ENTRY_W = $bits(FetchEntry);

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched instructions with their PCs.
// The head is read combinationally, so a pushed entry is visible on rdata
// in the cycle after the push.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : flush all entries; wins over push and pop
//   push     : write wdata at the tail
//   pop      : drop the head entry (ignored when empty)
//   wdata    : entry to write
//   rdata    : current head entry
//   count    : number of valid entries (0..DEPTH)
//   empty    : no valid entries
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    wrPtr;
    logic             full;
    logic             doPush;
    logic             doPop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rdata = mem[rdPtr];

    // A full queue may still accept a push when the head leaves in the same cycle.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries below count are ever read as valid.
    always_ff @(posedge clk) begin
        if (doPush && !clear) begin
            mem[wrPtr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Owns the fetch PC, issues word requests to a
// variable-latency in-order instruction memory, queues returned words with
// their PCs and hands them to decode under stall/redirect control.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   imem_req_valid  : request valid (credit limited, never during redirect)
//   imem_req_addr   : word-aligned request address (the fetch PC)
//   imem_req_ready  : memory accepts the request this cycle
//   imem_rsp_valid  : in-order response valid
//   imem_rsp_data   : returned instruction word
//   instr_valid     : queue head valid
//   instr, instr_pc : queue head word and its PC
//   stall           : decode does not consume this cycle
//   redirect        : taken branch, discard queued and in-flight fetches
//   redirect_pc     : new fetch PC, low two bits forced to zero
// ---------------------------------------------------------------------------
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   fetchPc;
    logic [31:0]   rspPc;
    logic [31:0]   redirectTarget;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] dropCnt;
    logic [CW-1:0] outstandingNext;
    logic [CW-1:0] dropNext;
    logic [CW-1:0] queueCount;
    logic [CW:0]   creditsUsed;
    logic          queueEmpty;
    logic          accept;
    logic          pushEn;
    logic          popEn;
    FetchEntry     pushEntry;
    FetchEntry     headEntry;

    assign redirectTarget = redirect_pc & ~32'd3;

    // In-flight plus queued work may never exceed the queue depth, which is
    // what guarantees every kept response finds a free slot.
    assign creditsUsed    = {1'b0, outstanding} + {1'b0, queueCount};
    assign imem_req_valid = !rst && (creditsUsed < (CW+1)'(QDEPTH)) && !redirect;
    assign imem_req_addr  = fetchPc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses owed to a discarded path are swallowed while dropCnt is non-zero.
    assign pushEn    = imem_rsp_valid && (dropCnt == '0) && !redirect;
    assign popEn     = instr_valid && !stall && !redirect;
    assign pushEntry = '{pc: rspPc, instr: imem_rsp_data};

    // With an empty queue the head shows a NOP at the PC expected next.
    assign instr_valid = !queueEmpty;
    assign instr       = queueEmpty ? NOP_INSTR : headEntry.instr;
    assign instr_pc    = queueEmpty ? rspPc : headEntry.pc;

    // Every response retires one outstanding request, dropped or kept. On a
    // redirect everything still in flight after this cycle becomes dropped.
    always_comb begin
        outstandingNext = outstanding + CW'(accept) - CW'(imem_rsp_valid);
        dropNext        = dropCnt;
        if (redirect) begin
            dropNext = outstandingNext;
        end else if (imem_rsp_valid && (dropCnt != '0)) begin
            dropNext = dropCnt - CW'(1);
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstandingNext;
            dropCnt     <= dropNext;
            if (redirect) begin
                fetchPc <= redirectTarget;
                rspPc   <= redirectTarget;
            end else begin
                if (accept) begin
                    fetchPc <= fetchPc + PC_STEP;
                end
                if (pushEn) begin
                    rspPc <= rspPc + PC_STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) instrQueue (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (pushEn),
        .pop   (popEn),
        .wdata (pushEntry),
        .rdata (headEntry),
        .count (queueCount),
        .empty (queueEmpty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Bench for fetch_unit: an in-order variable-latency memory model, a driver
// issuing directed and random stall/redirect/ready patterns, and a monitor
// comparing the DUT against an abstract model of the fetch stream.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import pipeline_pkg::*;

    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    // A memory request in flight: address, cycle its response is due, and
    // whether a redirect has made it worthless.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } MemReq;

    // One instruction decode should receive next.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ExpInstr;

    MemReq       pending[$];
    ExpInstr     expQ[$];
    logic [31:0] expNext;
    logic [31:0] expReqPc;
    int          queued;
    int          cycle;
    int          lastDue;
    int          curLat;
    int          total;
    int          bad;

    fetch_unit #(
        .QDEPTH   (QDEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Keep the expected instruction stream topped up from the current path.
    task automatic extendExpected();
        while (expQ.size() < 2 * QDEPTH + 4) begin
            expQ.push_back('{pc: expNext, word: memWord(expNext)});
            expNext = expNext + 32'd4;
        end
    endtask

    task automatic driveMemory();
        if (!rst && pending.size() > 0 && pending[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(pending[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // One cycle of stimulus, applied on the falling edge.
    task automatic applyStimulus(input bit st, input bit rdr, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        rst            = 1'b0;
        stall          = st;
        redirect       = rdr;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        if (rdr) begin
            expQ.delete();
            expNext = rpc & ~32'd3;
        end
        extendExpected();
        driveMemory();
    endtask

    // One cycle with reset held; the expected stream restarts at RESET_PC.
    task automatic applyReset();
        @(negedge clk);
        rst            = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        expQ.delete();
        expNext = RESET_PC;
        extendExpected();
    endtask

    // Monitor: compares outputs mid-cycle, then advances the model by the
    // events the coming rising edge will commit.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            checkOutput("rstReqValid", 32'(imem_req_valid), 32'd0);
            checkOutput("rstReqAddr", imem_req_addr, RESET_PC);
            checkOutput("rstInstrValid", 32'(instr_valid), 32'd0);
            checkOutput("rstInstr", instr, 32'h0);
            checkOutput("rstInstrPc", instr_pc, RESET_PC);
            pending.delete();
            queued   = 0;
            expReqPc = RESET_PC;
            lastDue  = cycle;
        end else begin
            bit    expReqValid;
            bit    popNow;
            int    dueAt;
            MemReq done;
            expReqValid = (pending.size() + queued < QDEPTH) && !redirect;
            checkOutput("reqValid", 32'(imem_req_valid), 32'(expReqValid));
            checkOutput("instrValid", 32'(instr_valid), 32'(queued > 0));
            if (expReqValid) begin
                checkOutput("reqAddr", imem_req_addr, expReqPc);
            end
            if (queued > 0 && !redirect && expQ.size() > 0) begin
                checkOutput("instrPc", instr_pc, expQ[0].pc);
                checkOutput("instr", instr, expQ[0].word);
            end
            popNow = (queued > 0) && !stall && !redirect;
            if (imem_rsp_valid) begin
                assert (pending.size() > 0)
                    else $error("[TB] memory response with nothing outstanding");
                if (pending.size() > 0) begin
                    done = pending.pop_front();
                    if (!done.stale && !redirect) begin
                        queued++;
                    end
                end
            end
            if (popNow) begin
                if (expQ.size() > 0) begin
                    void'(expQ.pop_front());
                end
                queued--;
            end
            if (redirect) begin
                foreach (pending[i]) begin
                    pending[i].stale = 1'b1;
                end
                queued   = 0;
                expReqPc = redirect_pc & ~32'd3;
            end else if (expReqValid && imem_req_ready) begin
                dueAt = (cycle + curLat > lastDue + 1) ? cycle + curLat : lastDue + 1;
                pending.push_back('{addr: expReqPc, due: dueAt, stale: 1'b0});
                lastDue  = dueAt;
                expReqPc = expReqPc + 32'd4;
            end
        end
        cycle++;
    end

    initial begin
        total          = 0;
        bad            = 0;
        cycle          = 0;
        lastDue        = 0;
        queued         = 0;
        curLat         = 1;
        expReqPc       = RESET_PC;
        expNext        = RESET_PC;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        repeat (3) applyReset();

        // Streaming with single-cycle memory.
        repeat (20) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Stall until the credits run out, then drain.
        repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect coinciding with a response and a pop, unaligned target.
        applyStimulus(1'b0, 1'b1, 32'h0000_0203, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Three-cycle memory with several requests in flight.
        curLat = 3;
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Address wrap at the top of memory.
        curLat = 1;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                curLat = $urandom_range(1, 4);
            end
            applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                          $urandom, $urandom_range(0, 3) != 0);
        end

        // Fill the queue, then reset in the middle of it.
        curLat = 1;
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) applyReset();
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the 5-stage pipeline. It sits directly upstream of the decode register and owns the fetch PC. It issues word requests to an instruction memory with variable latency, buffers returned instructions with their PCs in a small FIFO, and presents them to decode under a stall/redirect protocol. Branch redirects from decode discard queued and in-flight fetches.

## Interface
Parameters:
- QDEPTH, 4: instruction queue depth and maximum outstanding-plus-queued fetches; power of two, at least 2.
- RESET_PC, 32'h0000_0000: PC fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch byte address, word aligned.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  returned instruction word.
- instr_valid  out  1  queue head valid.
- instr  out  32  queue head instruction.
- instr_pc  out  32  PC of the queue head.
- stall  in  1  decode does not consume this cycle.
- redirect  in  1  taken branch: discard all fetched and in-flight work.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.

## Operation
- State: fetch_pc, rsp_pc, outstanding counter, drop counter, and queue (count 0..QDEPTH).
- Issue: imem_req_valid = !rst && (outstanding + count < QDEPTH) && !redirect. imem_req_addr = fetch_pc.
- Accept (valid & ready): fetch_pc += 4 (mod 2^32 wrap), outstanding += 1.
- Response with drop > 0: drop -= 1, outstanding -= 1, data discarded, rsp_pc unchanged.
- Response with drop == 0: push {rsp_pc, data}, rsp_pc += 4, outstanding -= 1.
- The credit rule guarantees a push never hits a full queue. A response while outstanding == 0 is a protocol error, flagged by a bench assertion.
- Consume: instr_valid && !stall pops the head. Push and pop in the same cycle keeps count unchanged.
- Redirect takes priority over everything else in its cycle:
  - queue cleared, fetch_pc and rsp_pc set to redirect_pc & ~3;
  - drop = outstanding after this cycle's response is counted, so a same-cycle response is dropped and counted as retired;
  - no request is issued in the redirect cycle; a same-cycle pop is ignored.
- stall has no effect on issue except through queue occupancy.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, instr_valid 0, instr 0, instr_pc RESET_PC. All counters 0, fetch_pc = rsp_pc = RESET_PC.
- First request is driven in the first cycle after rst deasserts.
- Response to instr_valid: 1 cycle (registered push, combinational head read).
- With single-cycle memory and no stall, throughput is 1 instruction per cycle.
- After a redirect, instr_valid is 0 in the next cycle and the request address is redirect_pc. The first redirected instruction is valid at the earliest 2 cycles after the redirect plus memory latency.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous). In-flight memory responses after reset are the memory's responsibility; the memory is reset by the same rst.

## Structure
- Shared package pipeline_pkg:
  - INSTR_W = 32, PC_STEP = 4, NOP_INSTR = 32'h0;
  - a typedef of the fetch entry struct {pc, instr}.
- One sub-module: fetch_fifo, a synchronous FIFO.
  - Parameterised on width (64) and depth (QDEPTH).
  - Ports: clk, rst, clear, push, pop, wdata, rdata, count, empty.
  - clear has priority over push/pop.
- Counters are $clog2(QDEPTH)+1 bits wide.

## Test plan
- Reset release, 1-cycle memory, stall = 0 -> requests 0x0, 0x4, 0x8…; instr_pc follows 0x0, 0x4… one cycle behind the responses, no bubbles.
- stall held high, 1-cycle memory -> exactly QDEPTH fetches complete, then imem_req_valid = 0. Release stall -> entries drain in order, and issue resumes when a credit frees.
- 3-cycle memory latency with 3 requests in flight, redirect to 0x100 -> next 3 responses are dropped, and the first instr_valid shows instr_pc 0x100.
- Redirect in the same cycle as a response and a pop -> response dropped, queue empty, drop equals the remaining outstanding.
- redirect_pc = 0x203 -> request address 0x200. A fetch at 0xFFFF_FFFC is followed by a request at 0x0.
- rst asserted while 2 entries are queued -> instr_valid falls immediately, and the first request after release is RESET_PC.
